// File: rtl/div_pkg.sv
`default_nettype none
// ============================================================================
// Module  : div_pkg
// Brief   : Shared constants for the shared iterative divider sequencer:
//           FSM state encoding, default operand width, divide-by-zero quotient.
// Revision: 1.0 - initial release
// ============================================================================
package div_pkg;

  // Default operand/result width of the shared divider
  localparam int DIV_WIDTH = 32;

  // Sequencer state encoding
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  // Quotient reported for a zero divisor at the default width
  localparam logic [DIV_WIDTH-1:0] DIV0_QUOTIENT = {DIV_WIDTH{1'b1}};

endpackage : div_pkg
`default_nettype wire

// File: rtl/div_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : div_rr_arbiter
// Brief   : Combinational round-robin arbiter. The search for a requester
//           starts at i_ptr and wraps; outputs a one-hot grant and its index.
// Revision: 1.0 - initial release
// ============================================================================
module div_rr_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int ID_W    = 1
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [ID_W-1:0]    i_ptr,
  output logic [NUM_REQ-1:0] o_grant,
  output logic [ID_W-1:0]    o_id,
  output logic               o_any
);

  // Two passes: first the requesters at or above the pointer, then the wrap-around
  always_comb begin
    o_grant = '0;
    o_id    = '0;
    o_any   = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!o_any && i_req[i] && (i >= int'(i_ptr))) begin
        o_any      = 1'b1;
        o_grant[i] = 1'b1;
        o_id       = ID_W'(i);
      end
    end
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!o_any && i_req[i] && (i < int'(i_ptr))) begin
        o_any      = 1'b1;
        o_grant[i] = 1'b1;
        o_id       = ID_W'(i);
      end
    end
  end

endmodule : div_rr_arbiter
`default_nettype wire

// File: rtl/div_share_sequencer.sv
`default_nettype none
// ============================================================================
// Module  : div_share_sequencer
// Brief   : Shares one iterative unsigned restoring divider between NUM_REQ
//           requesters. Round-robin accept, WIDTH shift/trial-subtract steps,
//           then a held response tagged with the requester id.
// Revision: 1.0 - initial release
// ============================================================================
module div_share_sequencer
  import div_pkg::*;
#(
  parameter int WIDTH   = DIV_WIDTH,
  parameter int NUM_REQ = 2,
  parameter int ID_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                       clk,
  input  logic                       Reset,
  input  logic [NUM_REQ-1:0]         req_valid,
  output logic [NUM_REQ-1:0]         req_ready,
  input  logic [NUM_REQ*WIDTH-1:0]   req_dividend,
  input  logic [NUM_REQ*WIDTH-1:0]   req_divisor,
  output logic                       rsp_valid,
  input  logic                       rsp_ready,
  output logic [ID_W-1:0]            rsp_id,
  output logic [WIDTH-1:0]           rsp_quotient,
  output logic [WIDTH-1:0]           rsp_remainder,
  output logic                       rsp_div0,
  output logic                       busy
);

  localparam int               CNT_W    = $clog2(WIDTH) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  logic [1:0]           r_state;
  logic [ID_W-1:0]      r_ptr;
  logic [ID_W-1:0]      r_id;
  logic [CNT_W-1:0]     r_cnt;
  logic [WIDTH-1:0]     r_divisor;
  // Upper half: partial remainder, lower half: dividend bits shifting into quotient
  logic [2*WIDTH-1:0]   r_remquo;
  logic                 r_div0;

  logic [NUM_REQ-1:0]   w_grant;
  logic [ID_W-1:0]      w_grant_id;
  logic                 w_any;
  logic [WIDTH-1:0]     w_sel_dividend;
  logic [WIDTH-1:0]     w_sel_divisor;
  logic                 w_ge;
  logic [WIDTH-1:0]     w_diff;
  logic [2*WIDTH-1:0]   w_step;
  logic [ID_W-1:0]      w_next_ptr;

  div_rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_arb (
    .i_req   (req_valid),
    .i_ptr   (r_ptr),
    .o_grant (w_grant),
    .o_id    (w_grant_id),
    .o_any   (w_any)
  );

  // Route the granted requester's operands to the load path
  always_comb begin
    w_sel_dividend = '0;
    w_sel_divisor  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_grant[i]) begin
        w_sel_dividend = req_dividend[i*WIDTH +: WIDTH];
        w_sel_divisor  = req_divisor[i*WIDTH +: WIDTH];
      end
    end
  end

  // One restoring step: the shifted-out MSB joins the remainder, giving a
  // (WIDTH+1)-bit trial value. When it is >= divisor the true difference is
  // below the divisor, so its low WIDTH bits are the whole new remainder.
  always_comb begin
    w_ge   = (r_remquo[2*WIDTH-1:WIDTH-1] >= {1'b0, r_divisor});
    w_diff = r_remquo[2*WIDTH-2:WIDTH-1] - r_divisor;
    if (w_ge) begin
      w_step = {w_diff, r_remquo[WIDTH-2:0], 1'b1};
    end else begin
      w_step = {r_remquo[2*WIDTH-2:0], 1'b0};
    end
  end

  assign w_next_ptr = (r_id == ID_W'(NUM_REQ - 1)) ? '0 : r_id + 1'b1;

  // Sequencer: accept and load in IDLE, iterate in CALC, hold result in DONE
  always_ff @(posedge clk) begin
    if (Reset) begin
      r_state   <= S_IDLE;
      r_ptr     <= '0;
      r_id      <= '0;
      r_cnt     <= '0;
      r_divisor <= '0;
      r_remquo  <= '0;
      r_div0    <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_any) begin
            r_id      <= w_grant_id;
            r_cnt     <= '0;
            r_divisor <= w_sel_divisor;
            if (w_sel_divisor == '0) begin
              // Result is known immediately: skip the iteration entirely
              r_remquo <= {w_sel_dividend, {WIDTH{1'b1}}};
              r_div0   <= 1'b1;
              r_state  <= S_DONE;
            end else begin
              r_remquo <= {{WIDTH{1'b0}}, w_sel_dividend};
              r_div0   <= 1'b0;
              r_state  <= S_CALC;
            end
          end
        end
        S_CALC: begin
          r_remquo <= w_step;
          r_cnt    <= r_cnt + 1'b1;
          if (r_cnt == CNT_LAST) begin
            r_state <= S_DONE;
          end
        end
        S_DONE: begin
          if (rsp_ready) begin
            r_state <= S_IDLE;
            r_ptr   <= w_next_ptr;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Grants are only offered while idle and out of reset
  assign req_ready     = ((r_state == S_IDLE) && !Reset) ? w_grant : '0;
  assign rsp_valid     = (r_state == S_DONE);
  assign busy          = (r_state != S_IDLE);
  assign rsp_id        = r_id;
  assign rsp_quotient  = r_remquo[WIDTH-1:0];
  assign rsp_remainder = r_remquo[2*WIDTH-1:WIDTH];
  assign rsp_div0      = r_div0;

endmodule : div_share_sequencer
`default_nettype wire
